// File: rtl/pipeline_stall_controller.sv
// Central stall/bubble controller for the five-stage pipeline: merges ID/EX/MEM
// stall requests and sequences EX multi-cycle MAC/DIV operations.
module pipeline_stall_controller #(
  parameter int unsigned MAC_CYCLES  = 2,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_stall_request,
  input  logic                   ex_start,
  input  logic [1:0]             ex_kind,
  input  logic                   ex_cancel,
  input  logic                   mem_stall_request,
  output logic [5:0]             stall,
  output logic [2:0]             bubble,
  output logic                   ex_busy,
  output logic                   ex_done,
  output logic [COUNT_WIDTH-1:0] ex_cycle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] MAC_LOAD = COUNT_WIDTH'(MAC_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] DIV_LOAD = COUNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   done_q;
  logic                   valid_start_s;
  logic                   ex_stall_s;
  logic [COUNT_WIDTH-1:0] load_val_s;

  assign valid_start_s = ex_start & (ex_kind != 2'b00);
  assign load_val_s    = (ex_kind == 2'b01) ? MAC_LOAD : DIV_LOAD;
  assign ex_stall_s    = ((state_q == S_IDLE) & valid_start_s & ~ex_cancel) | (state_q == S_RUN);

  // Sequencer FSM, counter and registered completion flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (ex_cancel) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_start_s) begin
            state_q <= S_RUN;
            cnt_q   <= load_val_s;
          end else begin
            cnt_q   <= '0;
          end
          done_q <= 1'b0;
        end
        S_RUN: begin
          // <=1 rather than ==1 keeps the counter from ever wrapping
          if (cnt_q <= CNT_ONE) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          // Result must stay valid until the instruction actually leaves EX
          if (!mem_stall_request) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q  <= 1'b1;
          end
          cnt_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Priority merge of stall sources into the hold vector
  always_comb begin
    stall = 6'b000000;
    if (mem_stall_request) begin
      stall = 6'b011111;
    end else if (ex_stall_s) begin
      stall = 6'b001111;
    end else if (id_stall_request) begin
      stall = 6'b000111;
    end else begin
      stall = 6'b000000;
    end
  end

  assign bubble[0] = stall[2] & ~stall[3];
  assign bubble[1] = stall[3] & ~stall[4];
  assign bubble[2] = stall[4] & ~stall[5];
  assign ex_busy   = ex_stall_s;
  assign ex_done   = done_q;
  assign ex_cycle  = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: timeline-based reference
// model, a table of single-cycle vectors, hand sequences and random stimulus.
module tb_pipeline_stall_controller;

  localparam int MAC_N = 2;
  localparam int DIV_N = 32;
  localparam int CW    = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_r, st_r, can_r, mem_r;
  logic [1:0]    kind_r;
  logic [5:0]    stall;
  logic [2:0]    bubble;
  logic          ex_busy, ex_done;
  logic [CW-1:0] ex_cycle;

  pipeline_stall_controller #(
    .MAC_CYCLES(MAC_N), .DIV_CYCLES(DIV_N), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .id_stall_request(id_r), .ex_start(st_r),
    .ex_kind(kind_r), .ex_cancel(can_r), .mem_stall_request(mem_r),
    .stall(stall), .bubble(bubble), .ex_busy(ex_busy), .ex_done(ex_done),
    .ex_cycle(ex_cycle)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: an accepted op is described by its start cycle and length
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_n      = 0;

  logic [5:0]    s_stall;
  logic [2:0]    s_bubble;
  logic          s_busy, s_done;
  logic [CW-1:0] s_cycle;

  typedef struct {
    logic       id;
    logic       st;
    logic [1:0] kind;
    logic       can;
    logic       mem;
    logic [5:0] e_stall;
    logic [2:0] e_bub;
    logic       e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_in(input logic id, input logic st, input logic [1:0] kind,
                        input logic can, input logic mem);
    id_r = id; st_r = st; kind_r = kind; can_r = can; mem_r = mem;
  endtask

  // One clock: sample at the falling edge, compare with the model, advance it
  task automatic step();
    int k;
    bit e_run, e_done, start_ok, e_ex;
    int e_cnt;
    logic [5:0] e_stall;
    logic [2:0] e_bub;
    @(negedge clock);
    s_stall = stall; s_bubble = bubble; s_busy = ex_busy; s_done = ex_done; s_cycle = ex_cycle;
    k        = cyc - m_start;
    e_run    = m_active && (k >= 1) && (k <= m_n - 1);
    e_done   = m_active && (k >= m_n);
    e_cnt    = e_run ? (m_n - k) : 0;
    start_ok = !m_active && st_r && (kind_r != 2'b00) && !can_r;
    e_ex     = start_ok || e_run;
    if (mem_r)        begin e_stall = 6'b011111; e_bub = 3'b100; end
    else if (e_ex)    begin e_stall = 6'b001111; e_bub = 3'b010; end
    else if (id_r)    begin e_stall = 6'b000111; e_bub = 3'b001; end
    else              begin e_stall = 6'b000000; e_bub = 3'b000; end
    if (reset) begin
      chk("model_stall",  32'(s_stall),  32'(e_stall));
      chk("model_bubble", 32'(s_bubble), 32'(e_bub));
      chk("model_busy",   32'(s_busy),   32'(e_ex));
      chk("model_done",   32'(s_done),   32'(e_done));
      chk("model_cycle",  32'(s_cycle),  32'(e_cnt));
    end
    @(posedge clock);
    if (!reset)                          m_active = 1'b0;
    else if (can_r)                      m_active = 1'b0;
    else if (start_ok) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_n      = (kind_r == 2'b01) ? MAC_N : DIV_N;
    end else if (e_done && !mem_r)       m_active = 1'b0;
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    vecs[0] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'b000000, 3'b000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 6'b000111, 3'b001, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6'b000000, 3'b000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 6'b001111, 3'b010, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 6'b001111, 3'b010, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 6'b011111, 3'b100, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 6'b011111, 3'b100, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 6'b000000, 3'b000, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 6'b000111, 3'b001, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 6'b011111, 3'b100, 1'b0};
    @(posedge clock); #1;

    // Reset held two cycles with every request high
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_stall_req_hi", 32'(s_stall), 32'h1f);
    chk("rst_bubble_req_hi", 32'(s_bubble), 32'h4);
    chk("rst_done", 32'(s_done), 32'h0);
    chk("rst_cycle", 32'(s_cycle), 32'h0);
    chk("rst_busy_cancel", 32'(s_busy), 32'h0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk("rst_stall_idle", 32'(s_stall), 32'h0);
    chk("rst_bubble_idle", 32'(s_bubble), 32'h0);

    // Table of single-cycle vectors applied from IDLE, each followed by a flush
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].id, vecs[i].st, vecs[i].kind, vecs[i].can, vecs[i].mem);
      step();
      chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_bubble", i), 32'(s_bubble), 32'(vecs[i].e_bub));
      chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vecs[i].e_busy));
      set_in(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();

    // DIV: 32 stall cycles, done at cycle 32, idle at 33
    for (int k = 0; k <= 33; k++) begin
      set_in(1'b0, (k == 0), 2'b10, 1'b0, 1'b0);
      step();
      chk("div_stall", 32'(s_stall), (k <= 31) ? 32'h0f : 32'h00);
      chk("div_bubble", 32'(s_bubble), (k <= 31) ? 32'h2 : 32'h0);
      chk("div_done", 32'(s_done), (k == 32) ? 32'h1 : 32'h0);
      chk("div_cycle", 32'(s_cycle), (k >= 1 && k <= 31) ? 32'(32 - k) : 32'h0);
    end

    // MAC: two stall cycles, done at cycle 2; kind 00 is ignored
    for (int k = 0; k <= 3; k++) begin
      set_in(1'b0, (k == 0), 2'b01, 1'b0, 1'b0);
      step();
      chk("mac_stall3", 32'(s_stall[3]), (k < 2) ? 32'h1 : 32'h0);
      chk("mac_done", 32'(s_done), (k == 2) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k <= 2; k++) begin
      set_in(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      step();
      chk("none_stall", 32'(s_stall), 32'h0);
      chk("none_done", 32'(s_done), 32'h0);
    end

    // Cancel at cycle 10 of a DIV
    for (int k = 0; k <= 40; k++) begin
      set_in(1'b0, (k == 0), 2'b10, (k == 10), 1'b0);
      step();
      chk("cancel_done", 32'(s_done), 32'h0);
      if (k >= 11) begin
        chk("cancel_stall", 32'(s_stall), 32'h0);
        chk("cancel_cycle", 32'(s_cycle), 32'h0);
      end
    end

    // DONE held by MEM stall (mem high for cycles 30..34, start held high)
    for (int k = 0; k <= 36; k++) begin
      set_in(1'b0, (k <= 35), 2'b10, 1'b0, (k >= 30 && k <= 34));
      step();
      if (k >= 30 && k <= 34) begin
        chk("memdone_stall", 32'(s_stall), 32'h1f);
        chk("memdone_bubble", 32'(s_bubble), 32'h4);
      end
      chk("memdone_done", 32'(s_done), (k >= 32 && k <= 35) ? 32'h1 : 32'h0);
      if (k >= 35) begin
        chk("memdone_norestart", 32'(s_stall), 32'h0);
        chk("memdone_busy", 32'(s_busy), 32'h0);
      end
    end

    // Load-use only
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk("lu_stall", 32'(s_stall), 32'h07);
    chk("lu_bubble", 32'(s_bubble), 32'h1);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk("lu_stall_next", 32'(s_stall), 32'h00);
    chk("lu_bubble_next", 32'(s_bubble), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) != 0);
      set_in(($urandom_range(2) == 0), ($urandom_range(3) == 0), 2'($urandom_range(3)),
             ($urandom_range(31) == 0), ($urandom_range(3) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
